// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative/absolute updates and a return-address stack.
// One operation per enabled cycle, priority ret > call > jump > sub > add > inc.
module pc_stack_unit #(
   parameter int unsigned      WIDTH        = 16,
   parameter int unsigned      STACK_DEPTH  = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] INC_STEP     = WIDTH'(1),
   localparam int unsigned     SP_W         = $clog2(STACK_DEPTH + 1),
   localparam int unsigned     IDX_W        = $clog2(STACK_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             add,
   input  logic             sub,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] offset,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] pc,
   output logic [SP_W-1:0]  sp,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             overflow_err,
   output logic             underflow_err
);

   typedef enum logic [2:0] {
      OP_NONE, OP_INC, OP_ADD, OP_SUB, OP_JUMP, OP_CALL, OP_RET
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] next_pc;
   logic [SP_W-1:0]  next_sp;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] pop_idx;
   logic             push;
   logic             ovf_set;
   logic             unf_set;

   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign ret_addr    = pc + INC_STEP;
   assign push_idx    = IDX_W'(sp);
   assign pop_idx     = IDX_W'(sp - SP_W'(1));

   always_comb begin
      op = OP_NONE;
      if (ret)       op = OP_RET;
      else if (call) op = OP_CALL;
      else if (jump) op = OP_JUMP;
      else if (sub)  op = OP_SUB;
      else if (add)  op = OP_ADD;
      else if (inc)  op = OP_INC;
   end

   // NOTE: every output of this block gets a default first so no path leaves a latch behind.
   always_comb begin
      next_pc = pc;
      next_sp = sp;
      push    = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (op)
         OP_INC:  next_pc = ret_addr;
         OP_ADD:  next_pc = pc + offset;
         OP_SUB:  next_pc = pc - offset;
         OP_JUMP: next_pc = target;
         OP_CALL: begin
            next_pc = target;
            if (stack_full) begin
               ovf_set = 1'b1;
            end else begin
               push    = 1'b1;
               next_sp = sp + SP_W'(1);
            end
         end
         OP_RET: begin
            if (stack_empty) begin
               next_pc = ret_addr;
               unf_set = 1'b1;
            end else begin
               next_pc = stack_mem[pop_idx];
               next_sp = sp - SP_W'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_VECTOR;
         sp            <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (en) begin
            pc <= next_pc;
            sp <= next_sp;
         end
         // A new error outranks a same-cycle clear.
         if (en && ovf_set)    overflow_err  <= 1'b1;
         else if (clr_err)     overflow_err  <= 1'b0;
         if (en && unf_set)    underflow_err <= 1'b1;
         else if (clr_err)     underflow_err <= 1'b0;
      end
   end

   // NOTE: the stack array has no reset; entries at or above sp are never read.
   always_ff @(posedge clk) begin
      if (en && push && !reset) stack_mem[push_idx] <= ret_addr;
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with default parameters.
module tb_pc_stack_unit;

   logic        clk = 1'b0;
   logic        reset, en, inc, add, sub, jump, call, ret, clr_err;
   logic [15:0] offset, target;
   logic [15:0] pc;
   logic [3:0]  sp;
   logic        stack_empty, stack_full, overflow_err, underflow_err;

   int n_checks = 0;
   int n_errors = 0;

   pc_stack_unit dut (
      .clk(clk), .reset(reset), .en(en), .inc(inc), .add(add), .sub(sub),
      .jump(jump), .call(call), .ret(ret), .clr_err(clr_err),
      .offset(offset), .target(target), .pc(pc), .sp(sp),
      .stack_empty(stack_empty), .stack_full(stack_full),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      {inc, add, sub, jump, call, ret, clr_err} = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_jump(input logic [15:0] t);
      jump = 1'b1; target = t; step();
   endtask

   task automatic check_state(input string tag, input logic [15:0] e_pc, input logic [3:0] e_sp);
      check({tag, "_pc"}, 32'(pc), 32'(e_pc));
      check({tag, "_sp"}, 32'(sp), 32'(e_sp));
   endtask

   logic [15:0] exp_ret [8];

   initial begin
      reset = 1'b1; en = 1'b0; offset = '0; target = '0;
      idle();
      step();
      check_state("reset", 16'h0000, 4'd0);
      check("reset_empty", 32'(stack_empty), 1);
      check("reset_full", 32'(stack_full), 0);
      check("reset_ovf", 32'(overflow_err), 0);
      check("reset_unf", 32'(underflow_err), 0);

      // Increment three times from the reset vector.
      reset = 1'b0; en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         inc = 1'b1; step();
         check_state($sformatf("inc%0d", i), 16'(i), 4'd0);
      end
      check("inc_empty", 32'(stack_empty), 1);

      // Relative arithmetic with wrap-around.
      do_jump(16'h0010);
      add = 1'b1; offset = 16'h0005; step();
      check("add", 32'(pc), 32'h0015);
      sub = 1'b1; offset = 16'h0020; step();
      check("sub_wrap", 32'(pc), 32'hFFF5);
      do_jump(16'hFFFF);
      inc = 1'b1; step();
      check("inc_wrap", 32'(pc), 32'h0000);

      // Nested call / return.
      do_jump(16'h0100);
      call = 1'b1; target = 16'h2000; step();
      check_state("call1", 16'h2000, 4'd1);
      call = 1'b1; target = 16'h3000; step();
      check_state("call2", 16'h3000, 4'd2);
      ret = 1'b1; step();
      check_state("ret1", 16'h2001, 4'd1);
      ret = 1'b1; step();
      check_state("ret2", 16'h0101, 4'd0);

      // Fill the stack, overflow once, then unwind.
      do_jump(16'h0500);
      exp_ret[0] = 16'h0501;
      for (int i = 1; i < 8; i++) exp_ret[i] = 16'h1000 + 16'(i - 1) * 16'h0100 + 16'h0001;
      for (int i = 0; i < 9; i++) begin
         call = 1'b1; target = 16'h1000 + 16'(i) * 16'h0100; step();
         if (i == 6) check("full_before_8th", 32'(stack_full), 0);
      end
      check_state("ovf_call", 16'h1800, 4'd8);
      check("ovf_full", 32'(stack_full), 1);
      check("ovf_flag", 32'(overflow_err), 1);
      for (int k = 0; k < 8; k++) begin
         ret = 1'b1; step();
         check_state($sformatf("unwind%0d", k), exp_ret[7 - k], 4'(7 - k));
      end
      check("unwind_empty", 32'(stack_empty), 1);
      check("ovf_sticky", 32'(overflow_err), 1);
      clr_err = 1'b1; step();
      check("ovf_clear", 32'(overflow_err), 0);

      // Return on an empty stack falls through.
      do_jump(16'h0040);
      ret = 1'b1; step();
      check_state("unf_ret", 16'h0041, 4'd0);
      check("unf_flag", 32'(underflow_err), 1);
      clr_err = 1'b1; ret = 1'b1; step();
      check("unf_set_wins", 32'(underflow_err), 1);
      check("unf_set_wins_pc", 32'(pc), 32'h0042);
      clr_err = 1'b1; step();
      check("unf_clear", 32'(underflow_err), 0);

      // Hold with en low, then priority on an empty stack.
      call = 1'b1; target = 16'h0700; step();
      check_state("pre_hold", 16'h0700, 4'd1);
      en = 1'b0;
      {inc, add, sub, jump, call, ret} = '1; offset = 16'h0033; target = 16'h0BAD; step();
      check_state("hold", 16'h0700, 4'd1);
      check("hold_ovf", 32'(overflow_err), 0);
      check("hold_unf", 32'(underflow_err), 0);
      en = 1'b1;
      ret = 1'b1; step();
      check_state("hold_ret", 16'h0043, 4'd0);
      call = 1'b1; ret = 1'b1; inc = 1'b1; target = 16'h0BAD; step();
      check_state("prio_ret", 16'h0044, 4'd0);
      check("prio_unf", 32'(underflow_err), 1);
      check("prio_no_ovf", 32'(overflow_err), 0);
      en = 1'b0; clr_err = 1'b1; step();
      check("clr_while_hold", 32'(underflow_err), 0);
      check("clr_while_hold_pc", 32'(pc), 32'h0044);

      // Reset discards a simultaneous call.
      en = 1'b1; call = 1'b1; target = 16'h9999; step();
      check_state("pre_reset", 16'h9999, 4'd1);
      reset = 1'b1; call = 1'b1; target = 16'h1234; step();
      check_state("reset_call", 16'h0000, 4'd0);
      check("reset_call_empty", 32'(stack_empty), 1);
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
